// File: rtl/hlsm_result_scoreboard_pkg.sv
// Shared types and helpers for the HLSM result scoreboard.
// State encoding, mask bit positions and saturating increment.
package hlsm_result_scoreboard_pkg;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_WAIT    = 2'd1,
    S_COMPARE = 2'd2,
    S_REPORT  = 2'd3
  } state_t;

  localparam int MASK_Z = 0;
  localparam int MASK_X = 1;

  // Increment v unless it already sits at vmax.
  function automatic logic [31:0] sat_inc(
    input logic [31:0] v,
    input logic [31:0] vmax
  );
    return (v >= vmax) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/hlsm_result_scoreboard_if.sv
// Bundle between the HLSM pair and the result scoreboard.
// Master drives Start/Done/results, slave returns the report.
interface hlsm_result_scoreboard_if #(
  parameter int DATAW = 32,
  parameter int CNTW  = 16,
  parameter int SKEWW = 8
);
  logic                    Start;
  logic                    DutDone;
  logic                    RefDone;
  logic signed [DATAW-1:0] dut_z;
  logic signed [DATAW-1:0] dut_x;
  logic signed [DATAW-1:0] ref_z;
  logic signed [DATAW-1:0] ref_x;
  logic                    Busy;
  logic                    ResultValid;
  logic                    Pass;
  logic                    Fail;
  logic                    Timeout;
  logic [1:0]              MismatchMask;
  logic [SKEWW-1:0]        SkewCycles;
  logic [CNTW-1:0]         TxnCount;
  logic [CNTW-1:0]         ErrCount;

  modport master (
    output Start, DutDone, RefDone,
    output dut_z, dut_x, ref_z, ref_x,
    input  Busy, ResultValid, Pass, Fail,
    input  Timeout, MismatchMask, SkewCycles,
    input  TxnCount, ErrCount
  );

  modport slave (
    input  Start, DutDone, RefDone,
    input  dut_z, dut_x, ref_z, ref_x,
    output Busy, ResultValid, Pass, Fail,
    output Timeout, MismatchMask, SkewCycles,
    output TxnCount, ErrCount
  );
endinterface

// File: rtl/hlsm_capture_side.sv
// Holds one side's z/x from the first Done seen while enabled.
// Later Done pulses are ignored until the next clear.
module hlsm_capture_side #(
  parameter int DATAW = 32
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_done,
  input  logic signed [DATAW-1:0] i_z,
  input  logic signed [DATAW-1:0] i_x,
  input  logic                    i_clear,
  input  logic                    i_enable,
  output logic                    o_captured,
  output logic signed [DATAW-1:0] o_z,
  output logic signed [DATAW-1:0] o_x
);

  logic                    r_cap;
  logic signed [DATAW-1:0] r_z;
  logic signed [DATAW-1:0] r_x;

  // Latch z/x once per transaction on the first enabled Done.
  always_ff @(posedge i_clk) begin
    if (i_rst || i_clear) begin
      r_cap <= 1'b0;
      r_z   <= '0;
      r_x   <= '0;
    end else if (i_enable && i_done && !r_cap) begin
      r_cap <= 1'b1;
      r_z   <= i_z;
      r_x   <= i_x;
    end
  end

  assign o_captured = r_cap;
  assign o_z        = r_z;
  assign o_x        = r_x;

endmodule

// File: rtl/hlsm_result_scoreboard.sv
// Compares HLSM DUT results against the reference model.
// Reports match/mismatch/timeout, Done skew and running counts.
module hlsm_result_scoreboard
  import hlsm_result_scoreboard_pkg::*;
#(
  parameter int DATAW    = 32,
  parameter int MAX_WAIT = 64,
  parameter int CNTW     = 16,
  parameter int SKEWW    = 8
) (
  input logic Clk,
  input logic Rst,
  hlsm_result_scoreboard_if.slave bus
);

  localparam int WCW = (MAX_WAIT > 2) ? $clog2(MAX_WAIT) : 1;
  localparam logic [WCW-1:0]   WLAST = WCW'(MAX_WAIT - 1);
  localparam logic [CNTW-1:0]  CMAX  = '1;
  localparam logic [SKEWW-1:0] SMAX  = '1;

  state_t           r_state;
  logic [WCW-1:0]   r_wait;
  logic [SKEWW-1:0] r_skew;
  logic             r_rv;
  logic             r_pass;
  logic             r_fail;
  logic             r_to;
  logic [1:0]       r_mask;
  logic [SKEWW-1:0] r_skew_out;
  logic [CNTW-1:0]  r_txn;
  logic [CNTW-1:0]  r_err;

  logic                    w_en;
  logic                    w_clear;
  logic                    w_dut_cap;
  logic                    w_ref_cap;
  logic signed [DATAW-1:0] w_dut_z;
  logic signed [DATAW-1:0] w_dut_x;
  logic signed [DATAW-1:0] w_ref_z;
  logic signed [DATAW-1:0] w_ref_x;
  logic                    w_dut_take;
  logic                    w_ref_take;
  logic                    w_both;
  logic                    w_one;
  logic [1:0]              w_mask;
  logic [CNTW-1:0]         w_txn_inc;
  logic [CNTW-1:0]         w_err_inc;
  logic [SKEWW-1:0]        w_skew_inc;

  assign w_en    = (r_state == S_WAIT);
  assign w_clear = (r_state == S_IDLE) && bus.Start;

  hlsm_capture_side #(.DATAW(DATAW)) u_dut_cap (
    .i_clk      (Clk),
    .i_rst      (Rst),
    .i_done     (bus.DutDone),
    .i_z        (bus.dut_z),
    .i_x        (bus.dut_x),
    .i_clear    (w_clear),
    .i_enable   (w_en),
    .o_captured (w_dut_cap),
    .o_z        (w_dut_z),
    .o_x        (w_dut_x)
  );

  hlsm_capture_side #(.DATAW(DATAW)) u_ref_cap (
    .i_clk      (Clk),
    .i_rst      (Rst),
    .i_done     (bus.RefDone),
    .i_z        (bus.ref_z),
    .i_x        (bus.ref_x),
    .i_clear    (w_clear),
    .i_enable   (w_en),
    .o_captured (w_ref_cap),
    .o_z        (w_ref_z),
    .o_x        (w_ref_x)
  );

  assign w_dut_take = w_en && bus.DutDone && !w_dut_cap;
  assign w_ref_take = w_en && bus.RefDone && !w_ref_cap;
  assign w_both     = (w_dut_cap || w_dut_take) &&
                      (w_ref_cap || w_ref_take);
  assign w_one      = w_dut_cap ^ w_ref_cap;

  assign w_txn_inc  = CNTW'(sat_inc(32'(r_txn), 32'(CMAX)));
  assign w_err_inc  = CNTW'(sat_inc(32'(r_err), 32'(CMAX)));
  assign w_skew_inc = SKEWW'(sat_inc(32'(r_skew), 32'(SMAX)));

  // Per-field difference of the held result sets.
  always_comb begin
    w_mask         = '0;
    w_mask[MASK_Z] = (w_dut_z != w_ref_z);
    w_mask[MASK_X] = (w_dut_x != w_ref_x);
  end

  // Transaction FSM with registered report outputs and counters.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_state    <= S_IDLE;
      r_wait     <= '0;
      r_skew     <= '0;
      r_rv       <= 1'b0;
      r_pass     <= 1'b0;
      r_fail     <= 1'b0;
      r_to       <= 1'b0;
      r_mask     <= '0;
      r_skew_out <= '0;
      r_txn      <= '0;
      r_err      <= '0;
    end else begin
      r_rv <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (bus.Start) begin
            r_state    <= S_WAIT;
            r_wait     <= '0;
            r_skew     <= '0;
            r_pass     <= 1'b0;
            r_fail     <= 1'b0;
            r_to       <= 1'b0;
            r_mask     <= '0;
            r_skew_out <= '0;
          end
        end
        S_WAIT: begin
          r_wait <= r_wait + WCW'(1);
          if (w_one) r_skew <= w_skew_inc;
          if (w_both) begin
            r_state <= S_COMPARE;
          end else if (r_wait == WLAST) begin
            r_state <= S_REPORT;
            r_to    <= 1'b1;
            r_fail  <= 1'b1;
            r_mask  <= '0;
            r_rv    <= 1'b1;
            r_txn   <= w_txn_inc;
            r_err   <= w_err_inc;
          end
        end
        S_COMPARE: begin
          r_state    <= S_REPORT;
          r_mask     <= w_mask;
          r_pass     <= (w_mask == 2'b00);
          r_fail     <= (w_mask != 2'b00);
          r_skew_out <= r_skew;
          r_rv       <= 1'b1;
          r_txn      <= w_txn_inc;
          if (w_mask != 2'b00) r_err <= w_err_inc;
        end
        S_REPORT: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.Busy         = (r_state != S_IDLE);
  assign bus.ResultValid  = r_rv;
  assign bus.Pass         = r_pass;
  assign bus.Fail         = r_fail;
  assign bus.Timeout      = r_to;
  assign bus.MismatchMask = r_mask;
  assign bus.SkewCycles   = r_skew_out;
  assign bus.TxnCount     = r_txn;
  assign bus.ErrCount     = r_err;

endmodule

// File: tb/tb_hlsm_result_scoreboard.sv
// Directed bench for hlsm_result_scoreboard.
// Instance A: default sizes; instance B: MAX_WAIT=8, CNTW=2.
module tb_hlsm_result_scoreboard;

  logic Clk;
  logic Rst;
  int   n_chk;
  int   n_fail;

  hlsm_result_scoreboard_if #(.DATAW(32), .CNTW(16), .SKEWW(8)) ifa ();
  hlsm_result_scoreboard_if #(.DATAW(32), .CNTW(2),  .SKEWW(8)) ifb ();

  hlsm_result_scoreboard #(
    .DATAW(32), .MAX_WAIT(64), .CNTW(16), .SKEWW(8)
  ) u_a (
    .Clk (Clk),
    .Rst (Rst),
    .bus (ifa)
  );

  hlsm_result_scoreboard #(
    .DATAW(32), .MAX_WAIT(8), .CNTW(2), .SKEWW(8)
  ) u_b (
    .Clk (Clk),
    .Rst (Rst),
    .bus (ifb)
  );

  always #5 Clk = ~Clk;

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic test_reset();
    Rst = 1'b1;
    step();
    Rst = 1'b0;
    n_chk++; if (ifa.Busy !== 1'b0) begin n_fail++;
      $display("FAIL reset_busy got %b want 0", ifa.Busy); end
    n_chk++; if (ifa.ResultValid !== 1'b0) begin n_fail++;
      $display("FAIL reset_rv got %b want 0", ifa.ResultValid); end
    n_chk++; if ({ifa.Pass, ifa.Fail, ifa.Timeout} !== 3'b000) begin n_fail++;
      $display("FAIL reset_flags got %b want 000", {ifa.Pass, ifa.Fail, ifa.Timeout}); end
    n_chk++; if (ifa.MismatchMask !== 2'b00 || ifa.SkewCycles !== 8'd0) begin n_fail++;
      $display("FAIL reset_mask_skew got %b/%0d want 00/0", ifa.MismatchMask, ifa.SkewCycles); end
    n_chk++; if (ifa.TxnCount !== 16'd0 || ifa.ErrCount !== 16'd0) begin n_fail++;
      $display("FAIL reset_counts got %0d/%0d want 0/0", ifa.TxnCount, ifa.ErrCount); end
    n_chk++; if (ifb.Busy !== 1'b0 || ifb.TxnCount !== 2'd0) begin n_fail++;
      $display("FAIL reset_b got %b/%0d want 0/0", ifb.Busy, ifb.TxnCount); end
  endtask

  task automatic test_match();
    ifa.Start = 1'b1;
    ifa.dut_z = 14; ifa.dut_x = -2;
    ifa.ref_z = 14; ifa.ref_x = -2;
    step();
    ifa.Start = 1'b0;
    n_chk++; if (ifa.Busy !== 1'b1) begin n_fail++;
      $display("FAIL match_busy got %b want 1", ifa.Busy); end
    repeat (5) step();
    ifa.DutDone = 1'b1; ifa.RefDone = 1'b1;
    step();
    ifa.DutDone = 1'b0; ifa.RefDone = 1'b0;
    n_chk++; if (ifa.ResultValid !== 1'b0) begin n_fail++;
      $display("FAIL match_rv_c7 got %b want 0", ifa.ResultValid); end
    step();
    n_chk++; if (ifa.ResultValid !== 1'b1) begin n_fail++;
      $display("FAIL match_rv_c8 got %b want 1", ifa.ResultValid); end
    n_chk++; if ({ifa.Pass, ifa.Fail, ifa.Timeout} !== 3'b100) begin n_fail++;
      $display("FAIL match_flags got %b want 100", {ifa.Pass, ifa.Fail, ifa.Timeout}); end
    n_chk++; if (ifa.MismatchMask !== 2'b00 || ifa.SkewCycles !== 8'd0) begin n_fail++;
      $display("FAIL match_mask_skew got %b/%0d want 00/0", ifa.MismatchMask, ifa.SkewCycles); end
    step();
    n_chk++; if (ifa.ResultValid !== 1'b0 || ifa.Busy !== 1'b0) begin n_fail++;
      $display("FAIL match_end got rv=%b busy=%b want 0/0", ifa.ResultValid, ifa.Busy); end
    n_chk++; if (ifa.TxnCount !== 16'd1 || ifa.ErrCount !== 16'd0) begin n_fail++;
      $display("FAIL match_counts got %0d/%0d want 1/0", ifa.TxnCount, ifa.ErrCount); end
  endtask

  task automatic test_skew_mismatch();
    ifa.Start = 1'b1;
    ifa.ref_z = 14; ifa.ref_x = 4;
    step();
    ifa.Start = 1'b0;
    repeat (5) step();
    ifa.DutDone = 1'b1; ifa.dut_z = 14; ifa.dut_x = -2;
    step();
    ifa.DutDone = 1'b0; ifa.dut_z = 99; ifa.dut_x = 99;
    repeat (2) step();
    ifa.RefDone = 1'b1;
    step();
    ifa.RefDone = 1'b0;
    n_chk++; if (ifa.ResultValid !== 1'b0) begin n_fail++;
      $display("FAIL skew_rv_c10 got %b want 0", ifa.ResultValid); end
    step();
    n_chk++; if (ifa.ResultValid !== 1'b1) begin n_fail++;
      $display("FAIL skew_rv_c11 got %b want 1", ifa.ResultValid); end
    n_chk++; if ({ifa.Pass, ifa.Fail, ifa.Timeout} !== 3'b010) begin n_fail++;
      $display("FAIL skew_flags got %b want 010", {ifa.Pass, ifa.Fail, ifa.Timeout}); end
    n_chk++; if (ifa.MismatchMask !== 2'b10) begin n_fail++;
      $display("FAIL skew_mask got %b want 10", ifa.MismatchMask); end
    n_chk++; if (ifa.SkewCycles !== 8'd3) begin n_fail++;
      $display("FAIL skew_cycles got %0d want 3", ifa.SkewCycles); end
    step();
    n_chk++; if (ifa.TxnCount !== 16'd2 || ifa.ErrCount !== 16'd1) begin n_fail++;
      $display("FAIL skew_counts got %0d/%0d want 2/1", ifa.TxnCount, ifa.ErrCount); end
    step();
    n_chk++; if (ifa.Fail !== 1'b1 || ifa.MismatchMask !== 2'b10) begin n_fail++;
      $display("FAIL skew_hold got %b/%b want 1/10", ifa.Fail, ifa.MismatchMask); end
  endtask

  task automatic test_ignored();
    int rv_seen;
    ifa.DutDone = 1'b1; ifa.RefDone = 1'b1;
    step();
    ifa.DutDone = 1'b0; ifa.RefDone = 1'b0;
    step();
    n_chk++; if (ifa.Busy !== 1'b0 || ifa.TxnCount !== 16'd2) begin n_fail++;
      $display("FAIL idle_done got busy=%b txn=%0d want 0/2", ifa.Busy, ifa.TxnCount); end
    ifa.Start = 1'b1;
    ifa.ref_z = 5; ifa.ref_x = 1;
    step();
    ifa.Start = 1'b0;
    step();
    ifa.Start = 1'b1;
    step();
    ifa.Start = 1'b0;
    ifa.DutDone = 1'b1; ifa.dut_z = 5; ifa.dut_x = 1;
    step();
    ifa.dut_z = 6;
    step();
    ifa.dut_z = 7;
    step();
    ifa.DutDone = 1'b0; ifa.dut_z = 0;
    step();
    ifa.RefDone = 1'b1;
    step();
    ifa.RefDone = 1'b0;
    n_chk++; if (ifa.ResultValid !== 1'b0) begin n_fail++;
      $display("FAIL ign_rv_c8 got %b want 0", ifa.ResultValid); end
    step();
    n_chk++; if (ifa.ResultValid !== 1'b1) begin n_fail++;
      $display("FAIL ign_rv_c9 got %b want 1", ifa.ResultValid); end
    n_chk++; if (ifa.Pass !== 1'b1 || ifa.MismatchMask !== 2'b00) begin n_fail++;
      $display("FAIL ign_first_value got pass=%b mask=%b want 1/00", ifa.Pass, ifa.MismatchMask); end
    ifa.Start = 1'b1;
    step();
    ifa.Start = 1'b0;
    n_chk++; if (ifa.Busy !== 1'b0) begin n_fail++;
      $display("FAIL ign_report_start got busy=%b want 0", ifa.Busy); end
    rv_seen = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (ifa.ResultValid === 1'b1) rv_seen++;
    end
    n_chk++; if (rv_seen !== 0) begin n_fail++;
      $display("FAIL ign_extra_reports got %0d want 0", rv_seen); end
    n_chk++; if (ifa.TxnCount !== 16'd3 || ifa.ErrCount !== 16'd1) begin n_fail++;
      $display("FAIL ign_counts got %0d/%0d want 3/1", ifa.TxnCount, ifa.ErrCount); end
  endtask

  task automatic test_reset_mid_wait();
    ifa.Start = 1'b1;
    step();
    ifa.Start = 1'b0;
    repeat (2) step();
    ifa.DutDone = 1'b1; ifa.dut_z = 3; ifa.dut_x = 3;
    step();
    ifa.DutDone = 1'b0;
    step();
    Rst = 1'b1;
    step();
    Rst = 1'b0;
    n_chk++; if (ifa.Busy !== 1'b0 || ifa.ResultValid !== 1'b0) begin n_fail++;
      $display("FAIL rst_mid_state got busy=%b rv=%b want 0/0", ifa.Busy, ifa.ResultValid); end
    n_chk++; if ({ifa.Pass, ifa.Fail, ifa.Timeout, ifa.MismatchMask} !== 5'b0) begin n_fail++;
      $display("FAIL rst_mid_flags got %b want 00000", {ifa.Pass, ifa.Fail, ifa.Timeout, ifa.MismatchMask}); end
    n_chk++; if (ifa.TxnCount !== 16'd0 || ifa.ErrCount !== 16'd0) begin n_fail++;
      $display("FAIL rst_mid_counts got %0d/%0d want 0/0", ifa.TxnCount, ifa.ErrCount); end
    ifa.Start = 1'b1;
    ifa.dut_z = -7; ifa.dut_x = 3;
    ifa.ref_z = -7; ifa.ref_x = 3;
    step();
    ifa.Start = 1'b0;
    step();
    ifa.DutDone = 1'b1; ifa.RefDone = 1'b1;
    step();
    ifa.DutDone = 1'b0; ifa.RefDone = 1'b0;
    step();
    n_chk++; if (ifa.ResultValid !== 1'b1 || ifa.Pass !== 1'b1) begin n_fail++;
      $display("FAIL rst_new_txn got rv=%b pass=%b want 1/1", ifa.ResultValid, ifa.Pass); end
    step();
    n_chk++; if (ifa.TxnCount !== 16'd1 || ifa.ErrCount !== 16'd0) begin n_fail++;
      $display("FAIL rst_new_counts got %0d/%0d want 1/0", ifa.TxnCount, ifa.ErrCount); end
  endtask

  task automatic test_timeout();
    ifb.Start = 1'b1;
    step();
    ifb.Start = 1'b0;
    step();
    ifb.DutDone = 1'b1; ifb.dut_z = 1; ifb.dut_x = 1;
    step();
    ifb.DutDone = 1'b0;
    repeat (5) step();
    n_chk++; if (ifb.ResultValid !== 1'b0 || ifb.Busy !== 1'b1) begin n_fail++;
      $display("FAIL to_c8 got rv=%b busy=%b want 0/1", ifb.ResultValid, ifb.Busy); end
    step();
    n_chk++; if (ifb.ResultValid !== 1'b1) begin n_fail++;
      $display("FAIL to_rv_c9 got %b want 1", ifb.ResultValid); end
    n_chk++; if ({ifb.Pass, ifb.Fail, ifb.Timeout, ifb.MismatchMask} !== 5'b01100) begin n_fail++;
      $display("FAIL to_flags got %b want 01100", {ifb.Pass, ifb.Fail, ifb.Timeout, ifb.MismatchMask}); end
    step();
    n_chk++; if (ifb.TxnCount !== 2'd1 || ifb.ErrCount !== 2'd1) begin n_fail++;
      $display("FAIL to_counts got %0d/%0d want 1/1", ifb.TxnCount, ifb.ErrCount); end
  endtask

  task automatic test_back_to_back_saturation();
    int exp_cnt;
    ifb.dut_z = 10; ifb.dut_x = 0;
    ifb.ref_z = 11; ifb.ref_x = 0;
    for (int i = 0; i < 4; i++) begin
      exp_cnt = (i + 1 > 3) ? 3 : i + 1;
      n_chk++; if (ifb.TxnCount !== 2'(exp_cnt) || ifb.ErrCount !== 2'(exp_cnt)) begin n_fail++;
        $display("FAIL sat_iter%0d got %0d/%0d want %0d/%0d", i, ifb.TxnCount, ifb.ErrCount, exp_cnt, exp_cnt); end
      ifb.Start = 1'b1;
      step();
      ifb.Start = 1'b0;
      n_chk++; if (ifb.Busy !== 1'b1) begin n_fail++;
        $display("FAIL b2b_accept%0d got %b want 1", i, ifb.Busy); end
      ifb.DutDone = 1'b1; ifb.RefDone = 1'b1;
      step();
      ifb.DutDone = 1'b0; ifb.RefDone = 1'b0;
      step();
      n_chk++; if (ifb.ResultValid !== 1'b1 || ifb.MismatchMask !== 2'b01) begin n_fail++;
        $display("FAIL b2b_report%0d got rv=%b mask=%b want 1/01", i, ifb.ResultValid, ifb.MismatchMask); end
      step();
    end
    n_chk++; if (ifb.TxnCount !== 2'd3 || ifb.ErrCount !== 2'd3) begin n_fail++;
      $display("FAIL sat_final got %0d/%0d want 3/3", ifb.TxnCount, ifb.ErrCount); end
  endtask

  initial begin
    n_chk = 0;
    n_fail = 0;
    Clk = 1'b0;
    Rst = 1'b1;
    ifa.Start = 1'b0; ifa.DutDone = 1'b0; ifa.RefDone = 1'b0;
    ifa.dut_z = 0; ifa.dut_x = 0; ifa.ref_z = 0; ifa.ref_x = 0;
    ifb.Start = 1'b0; ifb.DutDone = 1'b0; ifb.RefDone = 1'b0;
    ifb.dut_z = 0; ifb.dut_x = 0; ifb.ref_z = 0; ifb.ref_x = 0;
    test_reset();
    test_match();
    test_skew_mismatch();
    test_ignored();
    test_reset_mid_wait();
    test_timeout();
    test_back_to_back_saturation();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/hlsm_result_scoreboard.md
Name: hlsm_result_scoreboard

Overview:
Downstream checking stage for an HLSM DUT and its HLSM_ref reference model. Both are driven from the same Start.
- Captures each side's z/x outputs when that side's Done arrives.
- Compares the two result sets and measures the Done arrival skew.
- Keeps running transaction and error counts.
- Exposes a one-cycle ResultValid report per transaction, with a timeout if either side never completes.

Parameters:
DATAW, 32, width of the signed result words z and x
MAX_WAIT, 64, cycles in WAIT before a Timeout is declared (≥2)
CNTW, 16, width of the TxnCount and ErrCount counters
SKEWW, 8, width of SkewCycles

Ports:
Clk  in  1  system clock, rising-edge
Rst  in  1  synchronous, active-high reset
Start  in  1  same Start pulse given to DUT and reference
DutDone  in  1  DUT Done
RefDone  in  1  reference Done
dut_z  in  DATAW  DUT z, signed
dut_x  in  DATAW  DUT x, signed
ref_z  in  DATAW  reference z, signed
ref_x  in  DATAW  reference x, signed
Busy  out  1  high in any state other than IDLE
ResultValid  out  1  one-cycle report strobe
Pass  out  1  last transaction matched
Fail  out  1  last transaction mismatched or timed out
Timeout  out  1  last transaction timed out
MismatchMask  out  2  bit0 = z differs, bit1 = x differs
SkewCycles  out  SKEWW  |DutDone cycle − RefDone cycle|, saturating
TxnCount  out  CNTW  completed transactions, saturating
ErrCount  out  CNTW  failed transactions, saturating

Behaviour:
- Clock and reset: one clock (Clk); reset is synchronous and active-high (Rst).
- Reset values: all outputs 0; state IDLE; capture registers 0; capture flags clear.
- Rst mid-transaction aborts it with no report and no counter update.
- FSM states: IDLE, WAIT, COMPARE, REPORT.
- IDLE:
  - Start=1 → WAIT.
  - On that edge, clear Pass/Fail/Timeout/MismatchMask/SkewCycles, the capture flags, the wait counter and the skew counter.
  - Done inputs are ignored in IDLE.
- WAIT:
  - Wait counter increments every cycle.
  - First cycle DutDone=1 with dut_cap=0: latch dut_z/dut_x and set dut_cap. Same rule for the Ref side.
  - Later Done highs on an already-captured side are ignored.
  - Skew counter increments each cycle exactly one side is captured; saturates at 2^SKEWW−1.
  - Both Dones in the same cycle → SkewCycles=0.
  - Both flags set, or becoming set this cycle → COMPARE.
  - Otherwise, wait counter == MAX_WAIT−1 → REPORT with Timeout=1, Fail=1, MismatchMask=0.
  - Captures take priority over timeout in the same cycle.
- COMPARE (1 cycle):
  - MismatchMask = {x_dut≠x_ref, z_dut≠z_ref}, compared on the full DATAW bits.
  - Pass = (mask==0), Fail = !Pass.
  - SkewCycles is registered here → REPORT.
- REPORT (1 cycle):
  - ResultValid=1.
  - TxnCount+1; ErrCount+1 if Fail. Both saturate at all-ones.
  - → IDLE.
- Pass/Fail/Timeout/MismatchMask/SkewCycles hold until the next accepted Start.
- Start while Busy=1 is ignored; the running transaction is unaffected.
- Start in the REPORT cycle is ignored. A Start in the cycle after REPORT (IDLE) is accepted.
- Latency: both Dones sampled high in cycle k → ResultValid in cycle k+2.

Decomposition:
- Shared package holds:
  - state enum (IDLE=0, WAIT=1, COMPARE=2, REPORT=3);
  - MASK_Z=0 and MASK_X=1 bit indices;
  - a saturating-increment function used by all counters.
- One natural sub-module, hlsm_capture_side, instantiated twice (DUT, Ref):
  - inputs: done, z, x, clear, enable;
  - outputs: captured flag, held z, held x.

Test Plan:
- Match: Start at cycle 0; DutDone and RefDone both high at cycle 6; dut/ref z=14, x=−2 → ResultValid at cycle 8, Pass=1, MismatchMask=0, SkewCycles=0, TxnCount=1, ErrCount=0.
- Skewed mismatch: DutDone at cycle 6 with z=14, x=−2; RefDone at cycle 9 with z=14, x=4 → ResultValid at cycle 11, Fail=1, MismatchMask=2'b10, SkewCycles=3, ErrCount=1.
- Timeout: MAX_WAIT=8; Start, DutDone only, RefDone never → ResultValid 8 cycles after WAIT entry, Timeout=1, Fail=1, ErrCount increments.
- Ignored events:
  - Start pulsed during WAIT → no restart, a single report only.
  - DutDone held high for 3 cycles with changing dut_z → first-cycle value is used.
  - Done pulses in IDLE → no state change.
- Reset mid-WAIT: Rst=1 for 1 cycle after DutDone → all outputs 0, state IDLE. A new Start/Done pair then reports normally with TxnCount=1.
- Saturation: CNTW=2; 5 failing transactions → TxnCount=3, ErrCount=3, no wrap.
